// File: rtl/gfx_wbm_read_arbiter.sv
// gfx_wbm_read_arbiter: shares the single GFX Wishbone read master
// between NREQ read clients. Client 0 is texture fetch.
// Each grant covers exactly one reader transfer. The read data and a
// one-cycle ack go back to the granted client only.
// Build option: define GFX_RDARB_FIXED_PRIO_EN to make the lowest
// requesting index win every decision. The default is round-robin.
module gfx_wbm_read_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [NREQ-1:0]    req_i,
  input  logic [NREQ*30-1:0] addr_i,
  input  logic [NREQ*4-1:0]  sel_i,
  output logic [NREQ-1:0]    ack_o,
  output logic [31:0]        dat_o,
  output logic [NREQ-1:0]    grant_o,
  output logic               read_request_o,
  output logic [29:0]        rd_addr_o,
  output logic [3:0]         rd_sel_o,
  input  logic [31:0]        rd_dat_i,
  input  logic               rd_ack_i
);

  localparam int unsigned IDXW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic [31:0]     dat_q, dat_d;
  logic            rreq_q, rreq_d;
  logic [29:0]     addr_q, addr_d;
  logic [3:0]      sel_q, sel_d;

  logic [IDXW-1:0] win_idx;
  logic            win_vld;
  logic [29:0]     win_addr;
  logic [3:0]      win_sel;

`ifndef GFX_RDARB_FIXED_PRIO_EN
  logic [IDXW-1:0] last_q, last_d;
  logic [IDXW-1:0] owner_q, owner_d;
  int unsigned     cand;
`endif

  // Winner selection; loops run from the far end so the earliest match in search order wins.
  always_comb begin
    win_idx  = '0;
    win_vld  = |req_i;
    win_addr = '0;
    win_sel  = '0;
`ifdef GFX_RDARB_FIXED_PRIO_EN
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req_i[IDXW'(i)]) win_idx = IDXW'(i);
    end
`else
    cand = 0;
    for (int i = NREQ; i >= 1; i--) begin
      cand = 32'(last_q) + 32'(i);
      if (cand >= NREQ) cand = cand - NREQ;
      if (req_i[IDXW'(cand)]) win_idx = IDXW'(cand);
    end
`endif
    for (int k = 0; k < NREQ; k++) begin
      if (win_idx == IDXW'(k)) begin
        win_addr = addr_i[k*30 +: 30];
        win_sel  = sel_i[k*4 +: 4];
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ack_d   = '0;
    dat_d   = dat_q;
    rreq_d  = rreq_q;
    addr_d  = addr_q;
    sel_d   = sel_q;
`ifndef GFX_RDARB_FIXED_PRIO_EN
    last_d  = last_q;
    owner_d = owner_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (win_vld) begin
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          addr_d           = win_addr;
          sel_d            = win_sel;
          rreq_d           = 1'b1;
`ifndef GFX_RDARB_FIXED_PRIO_EN
          owner_d          = win_idx;
`endif
          state_d          = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (rd_ack_i) begin
          rreq_d  = 1'b0;
          dat_d   = rd_dat_i;
          ack_d   = grant_q;
          grant_d = '0;
`ifndef GFX_RDARB_FIXED_PRIO_EN
          last_d  = owner_q;
`endif
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // The reader may keep acking after completion; re-arbitrate only once it lets go.
        if (!rd_ack_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      ack_q   <= '0;
      dat_q   <= '0;
      rreq_q  <= 1'b0;
      addr_q  <= '0;
      sel_q   <= '0;
`ifndef GFX_RDARB_FIXED_PRIO_EN
      last_q  <= IDXW'(NREQ - 1);
      owner_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      dat_q   <= dat_d;
      rreq_q  <= rreq_d;
      addr_q  <= addr_d;
      sel_q   <= sel_d;
`ifndef GFX_RDARB_FIXED_PRIO_EN
      last_q  <= last_d;
      owner_q <= owner_d;
`endif
    end
  end

  assign ack_o          = ack_q;
  assign dat_o          = dat_q;
  assign grant_o        = grant_q;
  assign read_request_o = rreq_q;
  assign rd_addr_o      = addr_q;
  assign rd_sel_o       = sel_q;

endmodule

// File: tb/tb_gfx_wbm_read_arbiter.sv
// Directed bench for gfx_wbm_read_arbiter (NREQ=3); the bench plays the reader.
module tb_gfx_wbm_read_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  req;
  logic [89:0] addr;
  logic [11:0] sel;
  logic [2:0]  ack_o;
  logic [31:0] dat_o;
  logic [2:0]  grant_o;
  logic        read_request_o;
  logic [29:0] rd_addr_o;
  logic [3:0]  rd_sel_o;
  logic [31:0] rd_dat;
  logic        rd_ack;

  int vectors = 0;
  int miscompares = 0;

  gfx_wbm_read_arbiter #(.NREQ(3)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .sel_i(sel),
    .ack_o(ack_o), .dat_o(dat_o), .grant_o(grant_o),
    .read_request_o(read_request_o), .rd_addr_o(rd_addr_o), .rd_sel_o(rd_sel_o),
    .rd_dat_i(rd_dat), .rd_ack_i(rd_ack)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits a bounded number of cycles for read_request_o.
  task automatic wait_rreq(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (read_request_o) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; addr = '0; sel = '0; rd_dat = '0; rd_ack = 1'b0;
    tick(); tick();
    vectors++;
    if ({ack_o, grant_o, read_request_o, dat_o, rd_addr_o, rd_sel_o} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: ack=%b grant=%b rreq=%b dat=%h addr=%h sel=%h, want all 0",
               ack_o, grant_o, read_request_o, dat_o, rd_addr_o, rd_sel_o);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (read_request_o !== 1'b0) begin
      miscompares++; $display("FAIL reset_idle_rreq: got %b want 0", read_request_o);
    end
  endtask

  task automatic test_single();
    req = 3'b010; addr[30 +: 30] = 30'h40; sel[4 +: 4] = 4'hF;
    tick();
    vectors++;
    if (read_request_o !== 1'b1 || rd_addr_o !== 30'h40 || rd_sel_o !== 4'hF || grant_o !== 3'b010) begin
      miscompares++;
      $display("FAIL single_issue: rreq=%b addr=%h sel=%h grant=%b want 1/40/f/010",
               read_request_o, rd_addr_o, rd_sel_o, grant_o);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      vectors++;
      if (read_request_o !== 1'b1 || rd_addr_o !== 30'h40 || grant_o !== 3'b010 || ack_o !== 3'b000) begin
        miscompares++;
        $display("FAIL single_hold: rreq=%b addr=%h grant=%b ack=%b want 1/40/010/000",
                 read_request_o, rd_addr_o, grant_o, ack_o);
      end
    end
    rd_ack = 1'b1; rd_dat = 32'hDEADBEEF;
    tick();
    vectors++;
    if (ack_o !== 3'b010 || dat_o !== 32'hDEADBEEF || read_request_o !== 1'b0 || grant_o !== 3'b000) begin
      miscompares++;
      $display("FAIL single_done: ack=%b dat=%h rreq=%b grant=%b want 010/deadbeef/0/000",
               ack_o, dat_o, read_request_o, grant_o);
    end
    rd_ack = 1'b0; rd_dat = 32'h0; req = 3'b000;
    tick();
    vectors++;
    if (ack_o !== 3'b000 || dat_o !== 32'hDEADBEEF) begin
      miscompares++;
      $display("FAIL single_ack_one_cycle: ack=%b dat=%h want 000/deadbeef", ack_o, dat_o);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [2:0] exp_g;
    rst = 1'b1; tick(); rst = 1'b0;
    req = 3'b111;
    for (int n = 0; n < 5; n++) begin
`ifdef GFX_RDARB_FIXED_PRIO_EN
      exp_g = 3'b001;
`else
      exp_g = 3'b001 << (n % 3);
`endif
      wait_rreq(ok);
      vectors++;
      if (!ok || grant_o !== exp_g) begin
        miscompares++;
        $display("FAIL rr_grant_%0d: ok=%b grant=%b want %b", n, ok, grant_o, exp_g);
      end
      rd_ack = 1'b1; rd_dat = 32'h1000 + 32'(n);
      tick();
      vectors++;
      if (ack_o !== exp_g || dat_o !== 32'h1000 + 32'(n)) begin
        miscompares++;
        $display("FAIL rr_ack_%0d: ack=%b dat=%h want %b/%h", n, ack_o, dat_o, exp_g, 32'h1000 + 32'(n));
      end
      rd_ack = 1'b0;
      tick();
    end
    req = 3'b000;
    tick();
  endtask

  task automatic test_ack_stretch();
    bit ok;
    req = 3'b001;
    wait_rreq(ok);
    rd_ack = 1'b1; rd_dat = 32'h5555AAAA;
    tick();
    vectors++;
    if (!ok || ack_o !== 3'b001) begin
      miscompares++; $display("FAIL stretch_first_ack: ok=%b ack=%b want 001", ok, ack_o);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (read_request_o !== 1'b0 || ack_o !== 3'b000) begin
        miscompares++;
        $display("FAIL stretch_hold_%0d: rreq=%b ack=%b want 0/000", i, read_request_o, ack_o);
      end
    end
    rd_ack = 1'b0;
    tick();
    vectors++;
    if (read_request_o !== 1'b0) begin
      miscompares++; $display("FAIL stretch_fall_edge: rreq=%b want 0", read_request_o);
    end
    tick();
    vectors++;
    if (read_request_o !== 1'b1 || grant_o !== 3'b001) begin
      miscompares++;
      $display("FAIL stretch_reissue: rreq=%b grant=%b want 1/001", read_request_o, grant_o);
    end
    rd_ack = 1'b1; tick(); rd_ack = 1'b0; req = 3'b000; tick();
  endtask

  task automatic test_drop_busy();
    bit ok;
    req = 3'b100; addr[60 +: 30] = 30'h123; sel[8 +: 4] = 4'h3;
    wait_rreq(ok);
    vectors++;
    if (!ok || grant_o !== 3'b100 || rd_addr_o !== 30'h123 || rd_sel_o !== 4'h3) begin
      miscompares++;
      $display("FAIL drop_issue: ok=%b grant=%b addr=%h sel=%h want 100/123/3", ok, grant_o, rd_addr_o, rd_sel_o);
    end
    req = 3'b000;
    tick();
    vectors++;
    if (read_request_o !== 1'b1 || grant_o !== 3'b100) begin
      miscompares++;
      $display("FAIL drop_no_abort: rreq=%b grant=%b want 1/100", read_request_o, grant_o);
    end
    rd_ack = 1'b1; rd_dat = 32'hCAFEF00D;
    tick();
    vectors++;
    if (ack_o !== 3'b100 || dat_o !== 32'hCAFEF00D) begin
      miscompares++; $display("FAIL drop_ack: ack=%b dat=%h want 100/cafef00d", ack_o, dat_o);
    end
    rd_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (read_request_o !== 1'b0 || ack_o !== 3'b000) begin
        miscompares++;
        $display("FAIL drop_no_reissue_%0d: rreq=%b ack=%b want 0/000", i, read_request_o, ack_o);
      end
    end
  endtask

  task automatic test_reset_busy();
    bit ok;
    req = 3'b010;
    wait_rreq(ok);
    vectors++;
    if (!ok || grant_o !== 3'b010) begin
      miscompares++; $display("FAIL rstbusy_issue: ok=%b grant=%b want 010", ok, grant_o);
    end
    req = 3'b000; rst = 1'b1; rd_ack = 1'b1; rd_dat = 32'h77778888;
    tick();
    vectors++;
    if ({ack_o, grant_o, read_request_o, dat_o, rd_addr_o, rd_sel_o} !== '0) begin
      miscompares++;
      $display("FAIL rstbusy_outputs: ack=%b grant=%b rreq=%b dat=%h addr=%h sel=%h, want all 0",
               ack_o, grant_o, read_request_o, dat_o, rd_addr_o, rd_sel_o);
    end
    rst = 1'b0;
    tick();
    vectors++;
    if (ack_o !== 3'b000 || read_request_o !== 1'b0 || dat_o !== 32'h0) begin
      miscompares++;
      $display("FAIL rstbusy_stale_ack: ack=%b rreq=%b dat=%h want 000/0/0", ack_o, read_request_o, dat_o);
    end
    rd_ack = 1'b0; req = 3'b111;
    tick();
    vectors++;
    if (read_request_o !== 1'b1 || grant_o !== 3'b001) begin
      miscompares++;
      $display("FAIL rstbusy_first_grant: rreq=%b grant=%b want 1/001", read_request_o, grant_o);
    end
    rd_ack = 1'b1; rd_dat = 32'h0BADF00D;
    tick();
    vectors++;
    if (ack_o !== 3'b001 || dat_o !== 32'h0BADF00D) begin
      miscompares++; $display("FAIL rstbusy_done: ack=%b dat=%h want 001/0badf00d", ack_o, dat_o);
    end
    rd_ack = 1'b0; req = 3'b000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_ack_stretch();
    test_drop_busy();
    test_reset_busy();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
